uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, one byte of holding storage with acknowledge,
// framing-error and overrun pulses. CLKS_PER_BIT sets the bit period in clocks.
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    input  logic       rd_ack_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       framing_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_s;
    logic             rx_s_d;
    logic             falling;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    assign falling = rx_s_d & ~rx_s;

    // Bring the asynchronous line into the clock domain and keep a delayed copy for edge detection
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Frame sequencing, bit sampling and the holding register with its status pulses
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            data_o        <= '0;
            data_valid_o  <= 1'b0;
            framing_err_o <= 1'b0;
            overrun_o     <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            framing_err_o <= 1'b0;
            overrun_o     <= 1'b0;

            // An acknowledge releases the held byte; a completing frame below may reload it
            if (rd_ack_i && data_valid_o) begin
                data_valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (falling) begin
                        state    <= START;
                        baud_cnt <= '0;
                        busy_o   <= 1'b1;
                    end
                end

                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (baud_cnt == FULL_LAST) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        baud_cnt  <= '0;
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (baud_cnt == FULL_LAST) begin
                        state    <= IDLE;
                        busy_o   <= 1'b0;
                        baud_cnt <= '0;
                        if (rx_s) begin
                            if (!data_valid_o || rd_ack_i) begin
                                data_o       <= shift_reg;
                                data_valid_o <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                        end else begin
                            framing_err_o <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: stimulus pushes expected
// receiver events into a queue, an independent monitor pops and compares them.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CPB = 16;

    localparam logic [1:0] K_LOAD = 2'd0;
    localparam logic [1:0] K_ERR  = 2'd1;
    localparam logic [1:0] K_OVR  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rd_ack;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    bit   held;
    logic       prev_valid;
    logic [7:0] prev_data;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .rx_i          (rx),
        .rd_ack_i      (rd_ack),
        .data_o        (data),
        .data_valid_o  (data_valid),
        .framing_err_o (framing_err),
        .overrun_o     (overrun),
        .busy_o        (busy)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expect_event(input logic [1:0] kind, input logic [7:0] value);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event: got kind %0d data 0x%0h, expected no event", kind, value);
        end else begin
            e = exp_q.pop_front();
            check_output("event_kind", 32'(kind), 32'(e.kind));
            if (e.kind == K_LOAD && kind == K_LOAD) begin
                check_output("load_data", 32'(value), 32'(e.data));
            end
        end
    endtask

    // Hold the line at one level for a full bit period; called and returns on a falling clock edge
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Send one frame; the reference model decides the outcome from the held-byte status
    task automatic apply_stimulus(input logic [7:0] value, input bit stop_ok, input bit ack_at_done);
        logic [9:0] bits;
        exp_t e;
        bits = {stop_ok, value, 1'b0};
        if (stop_ok) begin
            if (!held || ack_at_done) begin
                e.kind = K_LOAD;
                held = 1'b1;
            end else begin
                e.kind = K_OVR;
            end
        end else begin
            e.kind = K_ERR;
        end
        e.data = value;
        exp_q.push_back(e);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    drive_bit(bits[i]);
                end
            end
            begin
                if (ack_at_done) begin
                    // completion happens 3 sync/edge cycles + half a bit + 9 bits after the start edge
                    repeat (3 + CPB / 2 + 9 * CPB - 1) @(negedge clk);
                    rd_ack = 1'b1;
                    @(negedge clk);
                    rd_ack = 1'b0;
                end
            end
        join
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        held = 1'b0;
        check_output("valid_after_ack", 32'(data_valid), 32'd0);
    endtask

    task automatic latency_frame(input logic [7:0] value);
        int n;
        n = 0;
        fork
            apply_stimulus(value, 1'b1, 1'b0);
            begin
                while (!data_valid && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                check_output("valid_latency", 32'(n), 32'(3 + CPB / 2 + 9 * CPB));
            end
        join
    endtask

    // Monitor: every event the DUT presents must match the head of the expectation queue
    always @(negedge clk) begin
        if (framing_err || overrun) begin
            check_output("err_ovr_exclusive", 32'(framing_err & overrun), 32'd0);
        end
        if (framing_err) begin
            expect_event(K_ERR, 8'h00);
        end
        if (overrun) begin
            expect_event(K_OVR, 8'h00);
        end
        if (data_valid && (!prev_valid || data != prev_data)) begin
            expect_event(K_LOAD, data);
        end
        prev_valid <= data_valid;
        prev_data  <= data;
    end

    initial begin
        checks     = 0;
        errors     = 0;
        held       = 1'b0;
        prev_valid = 1'b0;
        prev_data  = 8'h00;
        rst        = 1'b1;
        rx         = 1'b1;
        rd_ack     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_output("reset_data", 32'(data), 32'h00);
        check_output("reset_valid", 32'(data_valid), 32'd0);
        check_output("reset_ferr", 32'(framing_err), 32'd0);
        check_output("reset_ovr", 32'(overrun), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Plain frame with latency measurement
        latency_frame(8'hA5);
        check_output("a5_data", 32'(data), 32'hA5);
        check_output("a5_valid", 32'(data_valid), 32'd1);
        ack_pulse();
        repeat (5) @(negedge clk);

        // Short low glitch is rejected at mid start bit
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        check_output("glitch_busy_mid", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        check_output("glitch_busy_after", 32'(busy), 32'd0);
        check_output("glitch_valid", 32'(data_valid), 32'd0);
        check_output("glitch_ferr", 32'(framing_err), 32'd0);

        // Bad stop bit, then line held low
        apply_stimulus(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check_output("ferr_busy_low_line", 32'(busy), 32'd0);
        check_output("ferr_valid", 32'(data_valid), 32'd0);
        rx = 1'b1;
        repeat (20) @(negedge clk);

        // Back-to-back frames without acknowledge
        apply_stimulus(8'h11, 1'b1, 1'b0);
        apply_stimulus(8'h22, 1'b1, 1'b0);
        check_output("b2b_data", 32'(data), 32'h11);
        check_output("b2b_valid", 32'(data_valid), 32'd1);
        repeat (5) @(negedge clk);

        // Acknowledge landing exactly on the completion cycle
        apply_stimulus(8'h22, 1'b1, 1'b1);
        check_output("ackdone_data", 32'(data), 32'h22);
        check_output("ackdone_valid", 32'(data_valid), 32'd1);
        repeat (5) @(negedge clk);

        // Reset in the middle of data bit 3, then a clean frame
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst_data", 32'(data), 32'h00);
        check_output("midrst_valid", 32'(data_valid), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_ferr", 32'(framing_err), 32'd0);
        check_output("midrst_ovr", 32'(overrun), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        held = 1'b0;
        repeat (40) @(negedge clk);
        check_output("postrst_busy", 32'(busy), 32'd0);
        apply_stimulus(8'h5A, 1'b1, 1'b0);
        check_output("postrst_data", 32'(data), 32'h5A);
        check_output("postrst_valid", 32'(data_valid), 32'd1);

        // Random frames with random stop quality, gaps and acknowledges
        for (int f = 0; f < 12; f++) begin
            logic [7:0] value;
            bit         stop_ok;
            int         gap;
            value   = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 7) != 0);
            apply_stimulus(value, stop_ok, 1'b0);
            rx  = 1'b1;
            gap = $urandom_range(2, 20);
            for (int g = 0; g < gap; g++) begin
                if (g == 1 && $urandom_range(0, 1) == 1) begin
                    ack_pulse();
                end else begin
                    @(negedge clk);
                end
            end
            check_output("rand_valid", 32'(data_valid), 32'(held));
        end

        repeat (30) @(negedge clk);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
